// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the spi_command_arbiter slice.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DELIVER  = 2'd3
  } spi_arb_state_t;

  localparam int unsigned MAX_WIDTH   = 64;
  localparam int unsigned TIMER_WIDTH = 16;

  // Word returned to the requester when the watchdog gives up on the spi_master.
  localparam logic [MAX_WIDTH-1:0] TIMEOUT_DATA = '1;

  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/spi_command_arbiter_if.sv
// Requester-side and spi_master-side streams of spi_command_arbiter.
// slave: arbiter view; master: drivers/spi_master view.
interface spi_command_arbiter_if #(
  parameter int N = 2,
  parameter int W = 16
);

  logic [N-1:0]   s_cmd_tvalid;
  logic [N-1:0]   s_cmd_tready;
  logic [N*W-1:0] s_cmd_tdata;
  logic [N-1:0]   m_rsp_tvalid;
  logic [N-1:0]   m_rsp_tready;
  logic [W-1:0]   m_rsp_tdata;
  logic           spi_cmd_tvalid;
  logic           spi_cmd_tready;
  logic [W-1:0]   spi_cmd_tdata;
  logic           spi_rsp_tvalid;
  logic           spi_rsp_tready;
  logic [W-1:0]   spi_rsp_tdata;

  modport slave (
    input  s_cmd_tvalid, s_cmd_tdata, m_rsp_tready,
    input  spi_cmd_tready, spi_rsp_tvalid, spi_rsp_tdata,
    output s_cmd_tready, m_rsp_tvalid, m_rsp_tdata,
    output spi_cmd_tvalid, spi_cmd_tdata, spi_rsp_tready
  );

  modport master (
    output s_cmd_tvalid, s_cmd_tdata, m_rsp_tready,
    output spi_cmd_tready, spi_rsp_tvalid, spi_rsp_tdata,
    input  s_cmd_tready, m_rsp_tvalid, m_rsp_tdata,
    input  spi_cmd_tvalid, spi_cmd_tdata, spi_rsp_tready
  );

endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N.
module spi_rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_command_arbiter.sv
// Round-robin arbiter sharing one spi_master command/response stream pair between requesters.
// Optional WAIT_RSP watchdog and sticky timeout_err port: define SPI_ARB_TIMEOUT_EN.
//
//   state    | meaning
//   IDLE     | no transaction; grants the next requester in rr order
//   ISSUE    | presenting the latched command to the spi_master
//   WAIT_RSP | waiting for the spi_master response
//   DELIVER  | presenting the response to the granted requester
module spi_command_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int TRANSFER_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int GW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_command_arbiter_if.slave bus,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  spi_arb_state_t state, state_nx;

  logic [GW-1:0]             ptr;
  logic [GW-1:0]             pick;
  logic [GW-1:0]             gid_q;
  logic                      any_req;
  logic [TRANSFER_WIDTH-1:0] cmd_q;
  logic [TRANSFER_WIDTH-1:0] rsp_q;

  logic cmd_acc;
  logic spi_cmd_hs;
  logic spi_rsp_hs;
  logic rsp_hs;
  logic tmo;

  spi_rr_pick #(
    .N  (NUM_REQUESTERS),
    .GW (GW)
  ) u_pick (
    .req     (bus.s_cmd_tvalid),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign cmd_acc    = (state == IDLE) && any_req;
  assign spi_cmd_hs = (state == ISSUE) && bus.spi_cmd_tready;
  assign spi_rsp_hs = (state == WAIT_RSP) && bus.spi_rsp_tvalid;
  assign rsp_hs     = (state == DELIVER) && bus.m_rsp_tready[gid_q];

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] tmr;

  // A response arriving on the terminal cycle wins over the timeout.
  assign tmo = (state == WAIT_RSP) && !bus.spi_rsp_tvalid && (tmr == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (spi_cmd_hs)
        tmr <= TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
      else if ((state == WAIT_RSP) && (tmr != '0))
        tmr <= tmr - TIMER_WIDTH'(1);
      if (tmo)
        timeout_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (any_req)             state_nx = ISSUE;
      ISSUE:    if (bus.spi_cmd_tready)  state_nx = WAIT_RSP;
      WAIT_RSP: if (spi_rsp_hs || tmo)   state_nx = DELIVER;
      DELIVER:  if (rsp_hs)              state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cmd_tready   = '0;
    bus.m_rsp_tvalid   = '0;
    if (cmd_acc)            bus.s_cmd_tready[pick]  = 1'b1;
    if (state == DELIVER)   bus.m_rsp_tvalid[gid_q] = 1'b1;
    bus.spi_cmd_tvalid = (state == ISSUE);
    bus.spi_rsp_tready = (state == WAIT_RSP);
    busy               = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      rsp_q <= '0;
      gid_q <= '0;
      ptr   <= '0;
    end else begin
      if (cmd_acc) begin
        cmd_q <= bus.s_cmd_tdata[32'(pick) * TRANSFER_WIDTH +: TRANSFER_WIDTH];
        gid_q <= pick;
      end
      if (spi_rsp_hs)
        rsp_q <= bus.spi_rsp_tdata;
      else if (tmo)
        rsp_q <= TIMEOUT_DATA[TRANSFER_WIDTH-1:0];
      if (rsp_hs)
        ptr <= GW'(rr_next(32'(gid_q), NUM_REQUESTERS));
    end
  end

  assign bus.spi_cmd_tdata = cmd_q;
  assign bus.m_rsp_tdata   = rsp_q;
  assign grant_id          = gid_q;

endmodule
